// File: rtl/hyper_titan_pkg.sv
// hyper_titan_pkg
//   Shared types and constants for the 32-bit peripheral link.
//   - AXI-Lite address/data/strobe widths and response codes
//   - xbar_rule_32_t   : one address-map entry {idx, start_addr, end_addr}
//   - pl_s_axil_req_t  : AXI-Lite request  (master -> slave)
//   - pl_s_axil_resp_t : AXI-Lite response (slave -> master)
//   - pl_link_dflt_rule: the standard peripheral-link address map
package hyper_titan_pkg;

   localparam int unsigned AXIL_AW = 32;
   localparam int unsigned AXIL_DW = 32;
   localparam int unsigned AXIL_SW = AXIL_DW / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int unsigned PL_LINK_NUM_RULES = 4;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } xbar_rule_32_t;

   typedef struct packed {
      logic [AXIL_AW-1:0] aw_addr;
      logic [2:0]         aw_prot;
      logic               aw_valid;
      logic [AXIL_DW-1:0] w_data;
      logic [AXIL_SW-1:0] w_strb;
      logic               w_valid;
      logic               b_ready;
      logic [AXIL_AW-1:0] ar_addr;
      logic [2:0]         ar_prot;
      logic               ar_valid;
      logic               r_ready;
   } pl_s_axil_req_t;

   typedef struct packed {
      logic               aw_ready;
      logic               w_ready;
      logic [1:0]         b_resp;
      logic               b_valid;
      logic               ar_ready;
      logic [AXIL_DW-1:0] r_data;
      logic [1:0]         r_resp;
      logic               r_valid;
   } pl_s_axil_resp_t;

   // Standard peripheral-link map; unused entries decode nothing (start > end).
   function automatic xbar_rule_32_t pl_link_dflt_rule(input int unsigned r);
      xbar_rule_32_t rule;
      case (r)
         0:       rule = '{idx: 32'd0, start_addr: 32'h0000_2000, end_addr: 32'h0000_2FFF};
         1:       rule = '{idx: 32'd2, start_addr: 32'h0000_5000, end_addr: 32'h0000_5FFF};
         2:       rule = '{idx: 32'd3, start_addr: 32'h0000_3000, end_addr: 32'h0000_3FFF};
         3:       rule = '{idx: 32'd4, start_addr: 32'h0000_4000, end_addr: 32'h0000_4FFF};
         default: rule = '{idx: 32'd0, start_addr: 32'hFFFF_FFFF, end_addr: 32'h0000_0000};
      endcase
      return rule;
   endfunction

endpackage

// File: rtl/hyper_titan_sel_fifo.sv
// hyper_titan_sel_fifo
//   Small synchronous FIFO holding port-select codes of outstanding
//   transactions. The head is read combinationally so routing decisions
//   take effect in the same cycle.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i: write request and select value
//   pop_i        : remove head
//   data_o       : current head (valid only when !empty_o)
//   full_o, empty_o, count_o : occupancy status
module hyper_titan_sel_fifo #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push, do_pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (count_reg == CW'(DEPTH));
   assign empty_o = (count_reg == '0);
   assign count_o = count_reg;
   assign data_o  = mem_reg[rd_ptr_reg];

   // A push into a full FIFO is accepted only when a pop frees the slot.
   assign do_push = push_i & (!full_o | pop_i);
   assign do_pop  = pop_i & !empty_o;

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/axil_periph_demux.sv
// axil_periph_demux
//   AXI-Lite 1-to-NUM_MP demultiplexer with a runtime address map.
//   Requests pass through combinationally; responses return in request
//   order, tracked by three select FIFOs (W routing, B order, R order).
//   Unmapped addresses go to dflt_port_i when dflt_en_i, otherwise to an
//   internal DECERR responder (select code NUM_MP).
//   clk_i, rst_i  : clock, synchronous active-high reset
//   slv_req_i/slv_resp_o : upstream AXI-Lite port
//   mst_req_o/mst_resp_i : downstream AXI-Lite ports [NUM_MP]
//   addr_map_i    : address rules [NUM_RULES], static while busy
//   dflt_en_i, dflt_port_i : default-port routing for unmapped addresses
module axil_periph_demux
   import hyper_titan_pkg::*;
#(
   parameter int unsigned NUM_MP    = 5,
   parameter int unsigned NUM_RULES = 4,
   parameter int unsigned MAX_TRANS = 2,
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32,
   parameter type         req_t     = pl_s_axil_req_t,
   parameter type         resp_t    = pl_s_axil_resp_t,
   parameter type         rule_t    = xbar_rule_32_t
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  req_t                      slv_req_i,
   output resp_t                     slv_resp_o,
   output req_t                      mst_req_o   [NUM_MP],
   input  resp_t                     mst_resp_i  [NUM_MP],
   input  rule_t                     addr_map_i  [NUM_RULES],
   input  logic                      dflt_en_i,
   input  logic [$clog2(NUM_MP)-1:0] dflt_port_i
);

   localparam int unsigned SW = $clog2(NUM_MP + 1);
   localparam int unsigned CW = $clog2(MAX_TRANS + 1);
   localparam logic [SW-1:0] ERR_SEL = SW'(NUM_MP);

   // Scanning from the highest rule down lets the lowest matching index win.
   function automatic logic [SW-1:0] decode(
      input logic [AW-1:0]             addr,
      input rule_t                     map [NUM_RULES],
      input logic                      dflt_en,
      input logic [$clog2(NUM_MP)-1:0] dflt_port
   );
      logic [SW-1:0] sel;
      sel = dflt_en ? SW'(dflt_port) : ERR_SEL;
      for (int r = int'(NUM_RULES) - 1; r >= 0; r--) begin
         if (addr >= AW'(map[r].start_addr) && addr <= AW'(map[r].end_addr)) begin
            sel = (map[r].idx < NUM_MP) ? SW'(map[r].idx) : ERR_SEL;
         end
      end
      return sel;
   endfunction

   logic [SW-1:0] aw_sel, ar_sel, w_head, b_head, r_head;
   logic          w_full, w_empty, b_full, b_empty, r_full, r_empty;
   logic [CW-1:0] w_count, b_count, unused_r_count;
   logic          rst_hold_reg, pass;
   logic          aw_gate, ar_gate, aw_hs, ar_hs, w_hs, b_hs, r_hs;
   logic          aw_ready_sel, w_ready_sel, b_valid_sel, ar_ready_sel, r_valid_sel;
   logic [1:0]    b_resp_sel, r_resp_sel;
   logic [DW-1:0] r_data_sel;

   // Handshakes are blocked while reset is applied and for the cycle after.
   always_ff @(posedge clk_i) begin
      rst_hold_reg <= rst_i;
   end
   assign pass = !(rst_i | rst_hold_reg);

   assign aw_sel  = decode(slv_req_i.aw_addr, addr_map_i, dflt_en_i, dflt_port_i);
   assign ar_sel  = decode(slv_req_i.ar_addr, addr_map_i, dflt_en_i, dflt_port_i);
   assign aw_gate = pass & !w_full & !b_full;
   assign ar_gate = pass & !r_full;

   // Response-side mux. Defaults describe the DECERR responder; a matching
   // downstream port overrides them. An ERR B waits until its W has been
   // dropped, i.e. fewer W entries than B entries remain.
   always_comb begin
      aw_ready_sel = 1'b1;
      w_ready_sel  = 1'b1;
      b_valid_sel  = (w_count < b_count);
      b_resp_sel   = RESP_DECERR;
      ar_ready_sel = 1'b1;
      r_valid_sel  = 1'b1;
      r_data_sel   = '0;
      r_resp_sel   = RESP_DECERR;
      for (int i = 0; i < int'(NUM_MP); i++) begin
         if (aw_sel == SW'(i)) aw_ready_sel = mst_resp_i[i].aw_ready;
         if (w_head == SW'(i)) w_ready_sel  = mst_resp_i[i].w_ready;
         if (b_head == SW'(i)) begin
            b_valid_sel = mst_resp_i[i].b_valid;
            b_resp_sel  = mst_resp_i[i].b_resp;
         end
         if (ar_sel == SW'(i)) ar_ready_sel = mst_resp_i[i].ar_ready;
         if (r_head == SW'(i)) begin
            r_valid_sel = mst_resp_i[i].r_valid;
            r_data_sel  = mst_resp_i[i].r_data;
            r_resp_sel  = mst_resp_i[i].r_resp;
         end
      end
   end

   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = aw_gate & aw_ready_sel;
      slv_resp_o.w_ready  = pass & !w_empty & w_ready_sel;
      slv_resp_o.b_valid  = pass & !b_empty & b_valid_sel;
      slv_resp_o.b_resp   = b_resp_sel;
      slv_resp_o.ar_ready = ar_gate & ar_ready_sel;
      slv_resp_o.r_valid  = pass & !r_empty & r_valid_sel;
      slv_resp_o.r_data   = r_data_sel;
      slv_resp_o.r_resp   = r_resp_sel;
   end

   assign aw_hs = slv_req_i.aw_valid & slv_resp_o.aw_ready;
   assign w_hs  = slv_req_i.w_valid  & slv_resp_o.w_ready;
   assign b_hs  = slv_req_i.b_ready  & slv_resp_o.b_valid;
   assign ar_hs = slv_req_i.ar_valid & slv_resp_o.ar_ready;
   assign r_hs  = slv_req_i.r_ready  & slv_resp_o.r_valid;

   // Payload fields broadcast; only the selected port sees valid/ready.
   genvar gi;
   for (gi = 0; gi < NUM_MP; gi++) begin : g_mst
      req_t req_g;
      always_comb begin
         req_g          = slv_req_i;
         req_g.aw_valid = slv_req_i.aw_valid & aw_gate & (aw_sel == SW'(gi));
         req_g.w_valid  = slv_req_i.w_valid & pass & !w_empty & (w_head == SW'(gi));
         req_g.b_ready  = slv_req_i.b_ready & pass & !b_empty & (b_head == SW'(gi));
         req_g.ar_valid = slv_req_i.ar_valid & ar_gate & (ar_sel == SW'(gi));
         req_g.r_ready  = slv_req_i.r_ready & pass & !r_empty & (r_head == SW'(gi));
      end
      assign mst_req_o[gi] = req_g;
   end

   hyper_titan_sel_fifo #(.WIDTH(SW), .DEPTH(MAX_TRANS)) u_w_fifo (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(aw_hs), .data_i(aw_sel), .pop_i(w_hs),
      .data_o(w_head), .full_o(w_full), .empty_o(w_empty), .count_o(w_count)
   );

   hyper_titan_sel_fifo #(.WIDTH(SW), .DEPTH(MAX_TRANS)) u_b_fifo (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(aw_hs), .data_i(aw_sel), .pop_i(b_hs),
      .data_o(b_head), .full_o(b_full), .empty_o(b_empty), .count_o(b_count)
   );

   hyper_titan_sel_fifo #(.WIDTH(SW), .DEPTH(MAX_TRANS)) u_r_fifo (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(ar_hs), .data_i(ar_sel), .pop_i(r_hs),
      .data_o(r_head), .full_o(r_full), .empty_o(r_empty), .count_o(unused_r_count)
   );

endmodule

// File: tb/tb_axil_periph_demux.sv
// tb_axil_periph_demux
//   Directed and randomized stimulus for axil_periph_demux. Expected routing
//   comes from a reference decode of the address map; expected responses are
//   built from the data each modelled downstream port returns.
module tb_axil_periph_demux;
   import hyper_titan_pkg::*;

   localparam int NMP = 5;
   localparam int NR  = 4;

   logic            clk = 1'b0;
   logic            rst_i;
   pl_s_axil_req_t  slv_req;
   pl_s_axil_resp_t slv_resp;
   pl_s_axil_req_t  mst_req  [NMP];
   pl_s_axil_resp_t mst_resp [NMP];
   xbar_rule_32_t   addr_map [NR];
   logic            dflt_en;
   logic [2:0]      dflt_port;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axil_periph_demux dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .slv_req_i  (slv_req),
      .slv_resp_o (slv_resp),
      .mst_req_o  (mst_req),
      .mst_resp_i (mst_resp),
      .addr_map_i (addr_map),
      .dflt_en_i  (dflt_en),
      .dflt_port_i(dflt_port)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference routing: first matching rule in index order, else default/ERR.
   function automatic int model_port(input logic [31:0] addr);
      for (int r = 0; r < NR; r++) begin
         if (addr >= addr_map[r].start_addr && addr <= addr_map[r].end_addr)
            return (addr_map[r].idx < NMP) ? int'(addr_map[r].idx) : NMP;
      end
      return dflt_en ? int'(dflt_port) : NMP;
   endfunction

   task automatic read_one(input logic [31:0] addr);
      int          p;
      logic [31:0] d;
      p = model_port(addr);
      d = $urandom;
      slv_req.ar_addr  = addr;
      slv_req.ar_prot  = 3'($urandom_range(0, 7));
      slv_req.ar_valid = 1'b1;
      #1;
      for (int i = 0; i < NMP; i++)
         chk($sformatf("rd_ar_valid[%0d]@%h", i, addr), 64'(mst_req[i].ar_valid), 64'(i == p));
      chk("rd_ar_ready", 64'(slv_resp.ar_ready), 64'd1);
      if (p < NMP) chk("rd_ar_addr", 64'(mst_req[p].ar_addr), 64'(addr));
      step();
      slv_req.ar_valid = 1'b0;
      slv_req.r_ready  = 1'b1;
      if (p < NMP) begin
         mst_resp[p].r_valid = 1'b1;
         mst_resp[p].r_data  = d;
         mst_resp[p].r_resp  = RESP_OKAY;
      end
      #1;
      chk("rd_r_valid", 64'(slv_resp.r_valid), 64'd1);
      chk("rd_r_data", 64'(slv_resp.r_data), (p < NMP) ? 64'(d) : 64'd0);
      chk("rd_r_resp", 64'(slv_resp.r_resp), (p < NMP) ? 64'd0 : 64'd3);
      if (p < NMP) chk("rd_r_ready", 64'(mst_req[p].r_ready), 64'd1);
      step();
      slv_req.r_ready = 1'b0;
      if (p < NMP) mst_resp[p].r_valid = 1'b0;
      $display("txn READ  addr=%h port=%0d data=%h", addr, p, (p < NMP) ? d : 32'd0);
   endtask

   task automatic write_one(input logic [31:0] addr);
      int          p;
      logic [31:0] d;
      logic [1:0]  br;
      p  = model_port(addr);
      d  = $urandom;
      br = (p < NMP) ? 2'($urandom_range(0, 1)) : 2'b11;
      slv_req.aw_addr  = addr;
      slv_req.aw_valid = 1'b1;
      slv_req.w_data   = d;
      slv_req.w_strb   = 4'hF;
      slv_req.w_valid  = 1'b1;
      #1;
      for (int i = 0; i < NMP; i++)
         chk($sformatf("wr_aw_valid[%0d]@%h", i, addr), 64'(mst_req[i].aw_valid), 64'(i == p));
      chk("wr_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
      chk("wr_w_ready_pre_aw", 64'(slv_resp.w_ready), 64'd0);
      step();
      slv_req.aw_valid = 1'b0;
      #1;
      for (int i = 0; i < NMP; i++)
         chk($sformatf("wr_w_valid[%0d]@%h", i, addr), 64'(mst_req[i].w_valid), 64'(i == p));
      chk("wr_w_ready", 64'(slv_resp.w_ready), 64'd1);
      if (p < NMP) chk("wr_w_data", 64'(mst_req[p].w_data), 64'(d));
      step();
      slv_req.w_valid = 1'b0;
      slv_req.b_ready = 1'b1;
      if (p < NMP) begin
         mst_resp[p].b_valid = 1'b1;
         mst_resp[p].b_resp  = br;
      end
      #1;
      chk("wr_b_valid", 64'(slv_resp.b_valid), 64'd1);
      chk("wr_b_resp", 64'(slv_resp.b_resp), 64'(br));
      step();
      slv_req.b_ready = 1'b0;
      if (p < NMP) mst_resp[p].b_valid = 1'b0;
      $display("txn WRITE addr=%h port=%0d data=%h bresp=%0d", addr, p, d, br);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] base;

      addr_map[0] = '{idx: 32'd0, start_addr: 32'h2000, end_addr: 32'h2FFF};
      addr_map[1] = '{idx: 32'd2, start_addr: 32'h5000, end_addr: 32'h5FFF};
      addr_map[2] = '{idx: 32'd3, start_addr: 32'h3000, end_addr: 32'h3FFF};
      addr_map[3] = '{idx: 32'd4, start_addr: 32'h4000, end_addr: 32'h4FFF};
      dflt_en   = 1'b0;
      dflt_port = 3'd0;
      for (int i = 0; i < NMP; i++) begin
         mst_resp[i]          = '0;
         mst_resp[i].aw_ready = 1'b1;
         mst_resp[i].w_ready  = 1'b1;
         mst_resp[i].ar_ready = 1'b1;
      end

      // Reset with a request already pending: nothing may handshake.
      slv_req          = '0;
      slv_req.aw_addr  = 32'h2000;
      slv_req.aw_valid = 1'b1;
      slv_req.ar_addr  = 32'h7000;
      slv_req.ar_valid = 1'b1;
      rst_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;
      #1;
      chk("rst_aw_ready", 64'(slv_resp.aw_ready), 64'd0);
      chk("rst_ar_ready", 64'(slv_resp.ar_ready), 64'd0);
      chk("rst_mst0_aw_valid", 64'(mst_req[0].aw_valid), 64'd0);
      chk("rst_r_valid", 64'(slv_resp.r_valid), 64'd0);
      slv_req = '0;
      step();

      write_one(32'h5004);
      read_one(32'h7000);
      read_one(32'h2FFF);
      read_one(32'h3000);
      read_one(32'h1FFF);

      // Two ERR writes fill the W/B FIFOs; the third AW waits for a B.
      slv_req.aw_addr  = 32'h7000;
      slv_req.aw_valid = 1'b1;
      step();
      step();
      #1;
      chk("awstall_aw_ready_full", 64'(slv_resp.aw_ready), 64'd0);
      chk("awstall_b_before_w", 64'(slv_resp.b_valid), 64'd0);
      slv_req.w_valid = 1'b1;
      #1;
      chk("awstall_err_w_ready", 64'(slv_resp.w_ready), 64'd1);
      step();
      #1;
      chk("awstall_err_b_valid", 64'(slv_resp.b_valid), 64'd1);
      chk("awstall_err_b_resp", 64'(slv_resp.b_resp), 64'd3);
      chk("awstall_aw_ready_bfull", 64'(slv_resp.aw_ready), 64'd0);
      slv_req.b_ready = 1'b1;
      step();
      #1;
      chk("awstall_aw_ready_after_b", 64'(slv_resp.aw_ready), 64'd1);
      step();
      slv_req.aw_valid = 1'b0;
      repeat (4) step();
      slv_req.w_valid = 1'b0;
      slv_req.b_ready = 1'b0;
      #1;
      chk("awstall_drained_b", 64'(slv_resp.b_valid), 64'd0);
      chk("awstall_drained_w", 64'(slv_resp.w_ready), 64'd0);
      step();

      dflt_en   = 1'b1;
      dflt_port = 3'd1;
      read_one(32'h7000);
      write_one(32'h7000);
      dflt_en = 1'b0;
      addr_map[1].idx = 32'd7;
      read_one(32'h5008);
      addr_map[1].idx = 32'd2;

      // In-order R: port 4 answers late, port 0 early but must wait.
      slv_req.ar_addr  = 32'h4000;
      slv_req.ar_valid = 1'b1;
      step();
      slv_req.ar_addr = 32'h2000;
      step();
      slv_req.ar_valid    = 1'b0;
      slv_req.r_ready     = 1'b1;
      mst_resp[0].r_valid = 1'b1;
      mst_resp[0].r_data  = 32'hA0A0_0000;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("order_p0_r_ready_c%0d", c), 64'(mst_req[0].r_ready), 64'd0);
         chk($sformatf("order_r_valid_c%0d", c), 64'(slv_resp.r_valid), 64'd0);
         step();
      end
      mst_resp[4].r_valid = 1'b1;
      mst_resp[4].r_data  = 32'h4444_4444;
      #1;
      chk("order_first_data", 64'(slv_resp.r_data), 64'h4444_4444);
      chk("order_p4_r_ready", 64'(mst_req[4].r_ready), 64'd1);
      chk("order_p0_still_blocked", 64'(mst_req[0].r_ready), 64'd0);
      step();
      mst_resp[4].r_valid = 1'b0;
      #1;
      chk("order_second_data", 64'(slv_resp.r_data), 64'hA0A0_0000);
      chk("order_p0_r_ready", 64'(mst_req[0].r_ready), 64'd1);
      step();
      mst_resp[0].r_valid = 1'b0;
      slv_req.r_ready     = 1'b0;

      // AR stall: two reads outstanding block the third until an R pops.
      slv_req.ar_addr  = 32'h2000;
      slv_req.ar_valid = 1'b1;
      step();
      slv_req.ar_addr = 32'h3000;
      step();
      slv_req.ar_addr = 32'h4000;
      #1;
      chk("arstall_ready", 64'(slv_resp.ar_ready), 64'd0);
      chk("arstall_p4_ar_valid", 64'(mst_req[4].ar_valid), 64'd0);
      step();
      mst_resp[0].r_valid = 1'b1;
      mst_resp[0].r_data  = 32'h0000_00A1;
      slv_req.r_ready     = 1'b1;
      #1;
      chk("arstall_r_data", 64'(slv_resp.r_data), 64'h0000_00A1);
      chk("arstall_ready_in_r_cycle", 64'(slv_resp.ar_ready), 64'd0);
      step();
      mst_resp[0].r_valid = 1'b0;
      #1;
      chk("arstall_ready_after_r", 64'(slv_resp.ar_ready), 64'd1);
      chk("arstall_p4_ar_valid_after", 64'(mst_req[4].ar_valid), 64'd1);
      step();
      slv_req.ar_valid    = 1'b0;
      mst_resp[3].r_valid = 1'b1;
      mst_resp[3].r_data  = 32'h0000_00A3;
      #1;
      chk("arstall_drain_p3", 64'(slv_resp.r_data), 64'h0000_00A3);
      step();
      mst_resp[3].r_valid = 1'b0;
      mst_resp[4].r_valid = 1'b1;
      mst_resp[4].r_data  = 32'h0000_00A4;
      #1;
      chk("arstall_drain_p4", 64'(slv_resp.r_data), 64'h0000_00A4);
      step();
      mst_resp[4].r_valid = 1'b0;
      slv_req.r_ready     = 1'b0;

      // W presented before its AW must stall.
      slv_req.w_data  = 32'h5A5A_5A5A;
      slv_req.w_strb  = 4'hF;
      slv_req.w_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("wfirst_w_ready_c%0d", c), 64'(slv_resp.w_ready), 64'd0);
         chk($sformatf("wfirst_p0_w_valid_c%0d", c), 64'(mst_req[0].w_valid), 64'd0);
         step();
      end
      slv_req.aw_addr  = 32'h2000;
      slv_req.aw_valid = 1'b1;
      #1;
      chk("wfirst_w_ready_aw_cycle", 64'(slv_resp.w_ready), 64'd0);
      step();
      slv_req.aw_valid = 1'b0;
      #1;
      chk("wfirst_w_ready_after_aw", 64'(slv_resp.w_ready), 64'd1);
      chk("wfirst_p0_w_valid", 64'(mst_req[0].w_valid), 64'd1);
      step();
      slv_req.w_valid     = 1'b0;
      slv_req.b_ready     = 1'b1;
      mst_resp[0].b_valid = 1'b1;
      #1;
      chk("wfirst_b_valid", 64'(slv_resp.b_valid), 64'd1);
      step();
      mst_resp[0].b_valid = 1'b0;
      slv_req.b_ready     = 1'b0;

      // Randomized traffic against the reference decode.
      for (int n = 0; n < 16; n++) begin
         dflt_en   = 1'($urandom_range(0, 1));
         dflt_port = 3'($urandom_range(0, NMP - 1));
         case ($urandom_range(0, 5))
            0:       base = 32'h2000;
            1:       base = 32'h3000;
            2:       base = 32'h4000;
            3:       base = 32'h5000;
            4:       base = 32'h7000;
            default: base = 32'h1000;
         endcase
         base = base + 32'($urandom_range(0, 32'hFFF));
         if ($urandom_range(0, 1) == 1) read_one(base);
         else                           write_one(base);
      end
      dflt_en = 1'b0;

      // Reset with two reads outstanding abandons them.
      slv_req.ar_addr  = 32'h2000;
      slv_req.ar_valid = 1'b1;
      step();
      step();
      slv_req.ar_valid    = 1'b0;
      mst_resp[0].r_valid = 1'b1;
      mst_resp[0].r_data  = 32'hDEAD_BEEF;
      #1;
      chk("rst2_r_valid_before", 64'(slv_resp.r_valid), 64'd1);
      rst_i           = 1'b1;
      slv_req.r_ready = 1'b1;
      step();
      rst_i = 1'b0;
      #1;
      chk("rst2_r_valid", 64'(slv_resp.r_valid), 64'd0);
      chk("rst2_ar_ready", 64'(slv_resp.ar_ready), 64'd0);
      chk("rst2_aw_ready", 64'(slv_resp.aw_ready), 64'd0);
      chk("rst2_p0_r_ready", 64'(mst_req[0].r_ready), 64'd0);
      step();
      #1;
      chk("rst2_r_fifo_empty", 64'(slv_resp.r_valid), 64'd0);
      chk("rst2_ar_ready_free", 64'(slv_resp.ar_ready), 64'd1);
      chk("rst2_w_fifo_empty", 64'(slv_resp.w_ready), 64'd0);
      mst_resp[0].r_valid = 1'b0;
      slv_req.r_ready     = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
